// File: rtl/issue_pkg.sv
// Shared constants, encodings and decode helper for the ALU issue controller.
// Consumed by alu_issue_ctrl and its testbench via import issue_pkg::*.
package issue_pkg;

  localparam int INSTR_W   = 32;
  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_NOR  = 3'b011,
    ALU_ADD  = 3'b100,
    ALU_SUB  = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_SLLV = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_WB     = 2'b10,
    ST_HALT   = 2'b11
  } issue_state_e;

  typedef struct packed {
    logic    legal;
    alu_op_e op;
  } dec_t;

  // Illegal words decode to ALU_AND so the op output stays at a benign value.
  function automatic dec_t decode_instr(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d.legal = 1'b1;
    d.op    = ALU_AND;
    if (op != OP_RTYPE) begin
      d.legal = 1'b0;
    end else begin
      case (funct)
        FUNCT_AND:  d.op = ALU_AND;
        FUNCT_OR:   d.op = ALU_OR;
        FUNCT_XOR:  d.op = ALU_XOR;
        FUNCT_NOR:  d.op = ALU_NOR;
        FUNCT_ADD:  d.op = ALU_ADD;
        FUNCT_SUB:  d.op = ALU_SUB;
        FUNCT_SLT:  d.op = ALU_SLT;
        FUNCT_SLLV: d.op = ALU_SLLV;
        default:    d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, register-file control and ALU flag bundle of the issue stage.
// slave = issue controller side, master = upstream/datapath side.
interface alu_issue_ctrl_if #(parameter int CNT_W = 16);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [4:0]       r_addr_a;
  logic [4:0]       r_addr_b;
  logic [4:0]       w_addr;
  logic [2:0]       alu_op;
  logic             write_reg;
  logic             alu_zf;
  logic             alu_of;
  logic             flag_zf;
  logic             flag_of;
  logic             busy;
  logic [CNT_W-1:0] retired;
  logic             illegal;

  modport slave (
    input  in_valid, in_instr, alu_zf, alu_of,
    output in_ready, r_addr_a, r_addr_b, w_addr, alu_op, write_reg,
           flag_zf, flag_of, busy, retired, illegal
  );

  modport master (
    output in_valid, in_instr, alu_zf, alu_of,
    input  in_ready, r_addr_a, r_addr_b, w_addr, alu_op, write_reg,
           flag_zf, flag_of, busy, retired, illegal
  );

endinterface

// File: rtl/issue_fifo.sv
// Synchronous FIFO for the instruction buffer; DEPTH must be a power of two >= 2.
// Pointers carry one extra wrap bit so full/empty need no occupancy counter.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage: buffers R-type words, decodes them and sequences the register-file write.
// Define ISSUE_ILLEGAL_TRAP_EN to trap illegal words (sticky flag + HALT) instead of retiring them as NOPs.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for a buffered word; pops the head when present
// ST_DECODE | registers read/write addresses and ALU op from the word
// ST_WB     | write strobe asserted; flags captured, retired counted
// ST_HALT   | illegal word trapped; only reset leaves (trap build only)
module alu_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_ctrl_if.slave  bus
);
  import issue_pkg::*;

  issue_state_e         state_q, state_d;
  logic [INSTR_W-1:0]   fifo_dout;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;
  logic [INSTR_W-1:0]   instr_q;
  dec_t                 dec;
  logic [4:0]           ra_q, rb_q, wa_q;
  alu_op_e              op_q;
  logic                 legal_q, wr_q;
  logic                 zf_q, of_q;
  logic [CNT_W-1:0]     retired_q;
  logic                 write_reg;

  assign push = bus.in_valid && !fifo_full;

  issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.in_instr),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    write_reg = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_WB;
      ST_WB: begin
        write_reg = wr_q;
`ifdef ISSUE_ILLEGAL_TRAP_EN
        state_d   = legal_q ? ST_IDLE : ST_HALT;
`else
        state_d   = ST_IDLE;
`endif
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dec = decode_instr(instr_q[OP_LSB +: 6], instr_q[FUNCT_LSB +: 6]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      instr_q <= '0;
    else if (pop)
      instr_q <= fifo_dout;
  end

  // Addresses and op are registered once per word and held through IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ra_q    <= '0;
      rb_q    <= '0;
      wa_q    <= '0;
      op_q    <= ALU_AND;
      legal_q <= 1'b0;
      wr_q    <= 1'b0;
    end else if (state_q == ST_DECODE) begin
      ra_q    <= instr_q[RS_LSB +: 5];
      rb_q    <= instr_q[RT_LSB +: 5];
      wa_q    <= instr_q[RD_LSB +: 5];
      op_q    <= dec.op;
      legal_q <= dec.legal;
      wr_q    <= dec.legal && (instr_q[RD_LSB +: 5] != 5'd0);
    end
  end

`ifdef ISSUE_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zf_q      <= 1'b0;
      of_q      <= 1'b0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else if (state_q == ST_WB) begin
      if (legal_q) begin
        zf_q      <= bus.alu_zf;
        of_q      <= bus.alu_of;
        retired_q <= retired_q + 1'b1;
      end else begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign bus.illegal = illegal_q;
`else
  // Illegal words still retire, but must not disturb the captured flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zf_q      <= 1'b0;
      of_q      <= 1'b0;
      retired_q <= '0;
    end else if (state_q == ST_WB) begin
      if (legal_q) begin
        zf_q <= bus.alu_zf;
        of_q <= bus.alu_of;
      end
      retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.illegal = 1'b0;
`endif

  assign bus.in_ready  = !fifo_full;
  assign bus.r_addr_a  = ra_q;
  assign bus.r_addr_b  = rb_q;
  assign bus.w_addr    = wa_q;
  assign bus.alu_op    = op_q;
  assign bus.write_reg = write_reg;
  assign bus.flag_zf   = zf_q;
  assign bus.flag_of   = of_q;
  assign bus.retired   = retired_q;
  assign bus.busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl; write pulses are logged by a monitor
// and compared against hand-encoded {rs, rt, rd, alu_op} tuples.
module tb_alu_issue_ctrl;

  logic clk;
  logic reset;
  int   cyc;
  int   n_asr;
  int   n_fail;
  int   exp_ret;

  alu_issue_ctrl_if #(.CNT_W(16)) bus ();

  alu_issue_ctrl #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [17:0] f;
  } ev_t;
  ev_t evq[$];

  always @(negedge clk) begin
    if (bus.write_reg === 1'b1)
      evq.push_back('{cyc, {bus.r_addr_a, bus.r_addr_b, bus.w_addr, bus.alu_op}});
  end

  function automatic logic [17:0] fld(input int ra, input int rb, input int wa, input int op);
    return {ra[4:0], rb[4:0], wa[4:0], op[2:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asr++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("push_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    n_asr    = 0;
    n_fail   = 0;
    cyc      = 0;
    reset    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.alu_zf   = 1'b0;
    bus.alu_of   = 1'b0;

    // reset values
    #22;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_write_reg", {31'd0, bus.write_reg}, 32'd0);
    check("rst_addr_op", {14'd0, bus.r_addr_a, bus.r_addr_b, bus.w_addr, bus.alu_op}, 32'd0);
    check("rst_flags", {30'd0, bus.flag_zf, bus.flag_of}, 32'd0);
    check("rst_retired", {16'd0, bus.retired}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: single add rd=3 rs=1 rt=2
    evq.delete();
    push(32'h0022_1820);
    wait_idle();
    check("t1_pulses", evq.size(), 32'd1);
    check("t1_fields", {14'd0, evq[0].f}, {14'd0, fld(1, 2, 3, 4)});
    check("t1_retired", {16'd0, bus.retired}, 32'd1);
    check("t1_hold_waddr", {27'd0, bus.w_addr}, 32'd3);
    check("t1_wr_low", {31'd0, bus.write_reg}, 32'd0);

    // 2: seven words back-to-back; buffer fills on the 6th accept
    evq.delete();
    push(32'h0022_1820);  // add  rs1  rt2  rd3
    push(32'h012A_4025);  // or   rs9  rt10 rd8
    push(32'h018D_5826);  // xor  rs12 rt13 rd11
    push(32'h01F0_7027);  // nor  rs15 rt16 rd14
    push(32'h0253_882A);  // slt  rs18 rt19 rd17
    push(32'h02B6_A004);  // sllv rs21 rt22 rd20
    check("t2_full_ready", {31'd0, bus.in_ready}, 32'd0);
    push(32'h00C6_3824);  // and  rs6  rt6  rd7
    wait_idle();
    check("t2_pulses", evq.size(), 32'd7);
    check("t2_f0", {14'd0, evq[0].f}, {14'd0, fld(1, 2, 3, 4)});
    check("t2_f1", {14'd0, evq[1].f}, {14'd0, fld(9, 10, 8, 1)});
    check("t2_f2", {14'd0, evq[2].f}, {14'd0, fld(12, 13, 11, 2)});
    check("t2_f3", {14'd0, evq[3].f}, {14'd0, fld(15, 16, 14, 3)});
    check("t2_f4", {14'd0, evq[4].f}, {14'd0, fld(18, 19, 17, 6)});
    check("t2_f5", {14'd0, evq[5].f}, {14'd0, fld(21, 22, 20, 7)});
    check("t2_f6", {14'd0, evq[6].f}, {14'd0, fld(6, 6, 7, 0)});
    for (int i = 1; i < 7; i++)
      check($sformatf("t2_gap%0d", i), evq[i].cyc - evq[i-1].cyc, 32'd3);
    check("t2_retired", {16'd0, bus.retired}, 32'd8);
    check("t2_ready_back", {31'd0, bus.in_ready}, 32'd1);

    // 3: sub with rd=0 -> no write, flags and count still update
    evq.delete();
    bus.alu_zf = 1'b1;
    bus.alu_of = 1'b0;
    push(32'h0085_0022);
    wait_idle();
    check("t3_pulses", evq.size(), 32'd0);
    check("t3_flags", {30'd0, bus.flag_zf, bus.flag_of}, 32'd2);
    check("t3_retired", {16'd0, bus.retired}, 32'd9);

    // 4: op=0x08 word
    evq.delete();
    bus.alu_zf = 1'b0;
    bus.alu_of = 1'b1;
    push(32'h2022_0005);
`ifdef ISSUE_ILLEGAL_TRAP_EN
    repeat (10) @(negedge clk);
    check("t4_illegal", {31'd0, bus.illegal}, 32'd1);
    check("t4_halt_busy", {31'd0, bus.busy}, 32'd1);
    check("t4_retired", {16'd0, bus.retired}, 32'd9);
    push(32'h00C6_3824);
    repeat (10) @(negedge clk);
    check("t4_no_issue", evq.size(), 32'd0);
    check("t4_halt_ready", {31'd0, bus.in_ready}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t4_rst_illegal", {31'd0, bus.illegal}, 32'd0);
    exp_ret = 0;
`else
    wait_idle();
    check("t4_pulses", evq.size(), 32'd0);
    check("t4_flags_kept", {30'd0, bus.flag_zf, bus.flag_of}, 32'd2);
    check("t4_retired", {16'd0, bus.retired}, 32'd10);
    check("t4_illegal", {31'd0, bus.illegal}, 32'd0);
    push(32'h00C6_3824);
    wait_idle();
    check("t4_next_pulses", evq.size(), 32'd1);
    check("t4_next_fields", {14'd0, evq[0].f}, {14'd0, fld(6, 6, 7, 0)});
    check("t4_next_flags", {30'd0, bus.flag_zf, bus.flag_of}, 32'd1);
    check("t4_next_retired", {16'd0, bus.retired}, 32'd11);
    exp_ret = 11;
`endif

    // 6: sub with zf=of=1 captured and held, then cleared by an and
    evq.delete();
    bus.alu_zf = 1'b1;
    bus.alu_of = 1'b1;
    push(32'h0022_1822);
    wait_idle();
    check("t6_fields", {14'd0, evq[0].f}, {14'd0, fld(1, 2, 3, 5)});
    check("t6_flags", {30'd0, bus.flag_zf, bus.flag_of}, 32'd3);
    bus.alu_zf = 1'b0;
    bus.alu_of = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_flags_held", {30'd0, bus.flag_zf, bus.flag_of}, 32'd3);
    check("t6_retired", {16'd0, bus.retired}, exp_ret + 1);
    push(32'h00C6_3824);
    wait_idle();
    check("t6_flags_clr", {30'd0, bus.flag_zf, bus.flag_of}, 32'd0);
    check("t6_retired2", {16'd0, bus.retired}, exp_ret + 2);

    // 5: reset while the slt is in DECODE and an and is still buffered
    evq.delete();
    push(32'h0253_882A);
    push(32'h00C6_3824);
    reset = 1'b0;
    #1;
    check("t5_wr", {31'd0, bus.write_reg}, 32'd0);
    check("t5_retired", {16'd0, bus.retired}, 32'd0);
    check("t5_ready", {31'd0, bus.in_ready}, 32'd1);
    check("t5_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_pulse", evq.size(), 32'd0);
    check("t5_retired_after", {16'd0, bus.retired}, 32'd0);
    check("t5_empty_after", {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
